// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and types for the multiply/divide sequencer.
// ALU_ADD / ALU_SUB are the ALU control codes, also used by the ALU decoder.
// MD_* give the two-bit op encodings for MULTU, MULT, DIVU and DIV.
// md_state_t is the sequencer state enum.
package mips_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix
// Combinational sign handling for the multiply/divide sequencer.
// It has three independent paths:
//   abs_in / abs_en / abs_out       : when abs_en is set, the 32-bit
//                                     absolute value; otherwise a pass-through.
//   neg32_in / neg32_en / neg32_out : 32-bit two's-complement negate, when enabled.
//   neg64_in / neg64_en / neg64_out : 64-bit two's-complement negate, when enabled.
// The sequencer uses the magnitude paths in PREP and the negate paths in FIX.
module md_sign_fix (
   input  logic [31:0] abs_in,
   input  logic        abs_en,
   output logic [31:0] abs_out,
   input  logic [31:0] neg32_in,
   input  logic        neg32_en,
   output logic [31:0] neg32_out,
   input  logic [63:0] neg64_in,
   input  logic        neg64_en,
   output logic [63:0] neg64_out
);

   // 0x80000000 maps to itself, which is also its correct unsigned magnitude.
   assign abs_out   = (abs_en && abs_in[31]) ? (~abs_in + 32'd1) : abs_in;
   assign neg32_out = neg32_en ? (~neg32_in + 32'd1) : neg32_in;
   assign neg64_out = neg64_en ? (~neg64_in + 64'd1) : neg64_in;

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
// Multi-cycle controller for MULT/MULTU/DIV/DIVU. It borrows the shared
// 32-bit ALU for 32 iterations and builds a 64-bit HI/LO result.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   start, op              : launch request and op code (accepted only in IDLE)
//   rs_val, rt_val         : multiplicand/dividend and multiplier/divisor
//   abort                  : flush; cancels an in-flight operation
//   alu_a, alu_b           : ALU operands driven during the ITER state
//   alu_control            : ALU op code driven during the ITER state
//   alu_result             : combinational result returned by the ALU
//   busy                   : high in PREP, ITER and FIX
//   done                   : one-cycle pulse; hi and lo are valid from this cycle
//   hi, lo                 : product high/low, or remainder/quotient
module md_sequencer
   import mips_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        abort,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t   state;
   logic [1:0]  op_r;
   logic [31:0] rs_r;
   logic [31:0] rt_r;
   logic [31:0] opb;
   logic [31:0] acc_hi;
   logic [31:0] acc_lo;
   logic        neg_q;
   logic        neg_r;
   logic [4:0]  cnt;

   logic        is_signed;
   logic        is_div;
   logic [31:0] rs_sh;
   logic        sub_ok;
   logic        carry;
   logic [31:0] mag_rs;
   logic [31:0] neg32_in;
   logic        neg32_en;
   logic [31:0] neg32_out;
   logic [63:0] neg64_in;
   logic        neg64_en;
   logic [63:0] neg64_out;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   assign is_signed = op_r[0];
   assign is_div    = op_r[1];

   // opb holds the multiplicand for multiplies and the divisor for divides.
   // acc_hi/acc_lo hold the product halves, or the remainder and the quotient.
   // The remainder uses 33 bits of headroom. If its top bit is set, the
   // shifted value is already larger than any divisor.
   assign rs_sh  = {acc_hi[30:0], acc_lo[31]};
   assign sub_ok = acc_hi[31] | (rs_sh >= opb);
   assign carry  = (alu_result < acc_hi);

   // In PREP the 32-bit negate path gives |rt|.
   // In FIX it negates the quotient. The 64-bit path negates the product.
   // For a divide, the low half of the 64-bit path negates the zero-extended
   // remainder.
   assign neg32_in = (state == S_FIX) ? acc_lo : rt_r;
   assign neg32_en = (state == S_FIX) ? neg_q  : (is_signed & rt_r[31]);
   assign neg64_in = is_div ? {32'd0, acc_hi} : {acc_hi, acc_lo};
   assign neg64_en = is_div ? neg_r : neg_q;

   md_sign_fix u_sign_fix (
      .abs_in    (rs_r),
      .abs_en    (is_signed),
      .abs_out   (mag_rs),
      .neg32_in  (neg32_in),
      .neg32_en  (neg32_en),
      .neg32_out (neg32_out),
      .neg64_in  (neg64_in),
      .neg64_en  (neg64_en),
      .neg64_out (neg64_out)
   );

   // The final result is selected here.
   // Divide by zero forces hi to the latched dividend and lo to all ones,
   // whatever the iterations produced.
   always_comb begin
      fix_hi = neg64_out[63:32];
      fix_lo = neg64_out[31:0];
      if (is_div) begin
         if (rt_r == 32'd0) begin
            fix_hi = rs_r;
            fix_lo = 32'hFFFF_FFFF;
         end else begin
            fix_hi = neg64_out[31:0];
            fix_lo = neg32_out;
         end
      end
   end

   // The ALU is driven only in ITER. In every other state the operands
   // and the control code are held at zero.
   always_comb begin
      alu_a       = 32'd0;
      alu_b       = 32'd0;
      alu_control = ALU_ADD;
      if (state == S_ITER) begin
         if (is_div) begin
            alu_a       = rs_sh;
            alu_b       = opb;
            alu_control = ALU_SUB;
         end else begin
            alu_a = acc_hi;
            alu_b = acc_lo[0] ? opb : 32'd0;
         end
      end
   end

   // Main sequencer. An abort in any non-IDLE state returns to IDLE and
   // leaves hi and lo untouched. An abort in IDLE also blocks start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         op_r   <= MD_MULTU;
         rs_r   <= 32'd0;
         rt_r   <= 32'd0;
         opb    <= 32'd0;
         acc_hi <= 32'd0;
         acc_lo <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         cnt    <= 5'd0;
      end else if (abort && (state != S_IDLE)) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  op_r  <= op;
                  rs_r  <= rs_val;
                  rt_r  <= rt_val;
                  busy  <= 1'b1;
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               opb    <= is_div ? neg32_out : mag_rs;
               acc_lo <= is_div ? mag_rs : neg32_out;
               acc_hi <= 32'd0;
               neg_q  <= is_signed & (rs_r[31] ^ rt_r[31]);
               neg_r  <= is_signed & rs_r[31];
               cnt    <= 5'd0;
               state  <= S_ITER;
            end
            S_ITER: begin
               if (is_div) begin
                  acc_hi <= sub_ok ? alu_result : rs_sh;
                  acc_lo <= {acc_lo[30:0], sub_ok};
               end else begin
                  acc_hi <= {carry, alu_result[31:1]};
                  acc_lo <= {alu_result[0], acc_lo[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'(ITERS - 1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Self-checking bench for md_sequencer. It provides the ALU, and a
// transaction-level model counts cycles from accept to done and computes
// results with plain 64-bit arithmetic. A compare process checks the DUT
// against the model on every cycle. Directed operations also pin hand-computed
// literal results.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        abort = 1'b0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: m_count is 0 when idle, 1..34 while busy, and 35 in the done cycle.
   bit          model_ready = 1'b0;
   int          m_count = 0;
   logic [1:0]  m_op = 2'b00;
   logic [31:0] m_rs = 32'd0;
   logic [31:0] m_rt = 32'd0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   // Literal expectations for the next done pulse.
   bit          pin_valid = 1'b0;
   logic [31:0] pin_hi = 32'd0;
   logic [31:0] pin_lo = 32'd0;

   md_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .abort       (abort),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   // This is the shared ALU: code 0001 subtracts, anything else adds.
   assign alu_result = (alu_control == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

   always #5 clk = ~clk;

   // Reference result. The {hi, lo} halves come from plain arithmetic.
   function automatic logic [63:0] md_ref(input logic [1:0] f_op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f_op)
         2'b00: p = {32'd0, a} * {32'd0, b};
         2'b01: p = sa * sb;
         2'b10: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else            p = {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFF_FFFF};
            end else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   // This is the behavioural model. It accepts an op only when idle and
   // delivers the result 34 cycles later. Abort and reset cancel the op.
   always @(posedge clk) begin
      if (reset) begin
         m_count     <= 0;
         m_hi        <= 32'd0;
         m_lo        <= 32'd0;
         model_ready <= 1'b1;
      end else if ((m_count != 0) && abort) begin
         m_count <= 0;
      end else if (m_count == 0) begin
         if (start && !abort) begin
            m_op    <= op;
            m_rs    <= rs_val;
            m_rt    <= rt_val;
            m_count <= 1;
         end
      end else if (m_count < 34) begin
         m_count <= m_count + 1;
      end else if (m_count == 34) begin
         {m_hi, m_lo} <= md_ref(m_op, m_rs, m_rt);
         m_count      <= 35;
      end else begin
         m_count <= 0;
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // This compare process runs every cycle, away from the active edge.
   always @(negedge clk) begin
      if (model_ready) begin
         check_output("busy", 64'(busy), 64'((m_count >= 1) && (m_count <= 34)));
         check_output("done", 64'(done), 64'(m_count == 35));
         check_output("hi", 64'(hi), 64'(m_hi));
         check_output("lo", 64'(lo), 64'(m_lo));
         if ((m_count >= 2) && (m_count <= 33)) begin
            check_output("alu_control_iter", 64'(alu_control), m_op[1] ? 64'd1 : 64'd0);
         end else begin
            check_output("alu_control_idle", 64'(alu_control), 64'd0);
            check_output("alu_a_idle", 64'(alu_a), 64'd0);
            check_output("alu_b_idle", 64'(alu_b), 64'd0);
         end
         if ((m_count == 35) && pin_valid) begin
            check_output("pin_hi", 64'(hi), 64'(pin_hi));
            check_output("pin_lo", 64'(lo), 64'(pin_lo));
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Request an op for one cycle. On return, the request edge has passed.
   task automatic apply_stimulus(input logic [1:0] s_op, input logic [31:0] s_rs,
                                 input logic [31:0] s_rt);
      op     = s_op;
      rs_val = s_rs;
      rt_val = s_rt;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
   endtask

   task automatic run_directed(input logic [1:0] s_op, input logic [31:0] s_rs,
                               input logic [31:0] s_rt, input logic [31:0] e_hi,
                               input logic [31:0] e_lo);
      pin_hi    = e_hi;
      pin_lo    = e_lo;
      pin_valid = 1'b1;
      apply_stimulus(s_op, s_rs, s_rt);
      repeat (36) cycle();
      pin_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (2) cycle();
      reset = 1'b0;
      cycle();

      run_directed(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_directed(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_directed(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_directed(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
      run_directed(2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
      run_directed(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // Abort in ITER cycle 10, together with a competing start.
      apply_stimulus(2'b10, 32'd1000, 32'd3);
      repeat (10) cycle();
      abort  = 1'b1;
      start  = 1'b1;
      op     = 2'b00;
      rs_val = 32'd5;
      rt_val = 32'd5;
      cycle();
      abort  = 1'b0;
      start  = 1'b0;
      repeat (40) cycle();
      run_directed(2'b00, 32'd1000, 32'd3, 32'd0, 32'd3000);

      // A start while busy must be ignored.
      pin_hi    = 32'hFFFF_FFFF;
      pin_lo    = 32'hFFFF_FFE2;
      pin_valid = 1'b1;
      apply_stimulus(2'b01, 32'hFFFF_FFFB, 32'd6);
      repeat (5) cycle();
      op     = 2'b10;
      rs_val = 32'd77;
      rt_val = 32'd4;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
      repeat (30) cycle();
      pin_valid = 1'b0;

      // Reset in the middle of ITER.
      apply_stimulus(2'b00, 32'h0001_2345, 32'h0000_0678);
      repeat (15) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (40) cycle();

      // Random operations, with random extra start pulses and occasional aborts.
      for (int t = 0; t < 40; t++) begin
         apply_stimulus(2'($urandom_range(0, 3)), pick(), pick());
         for (int c = 0; c < 36; c++) begin
            if ((m_count != 0) && ($urandom_range(0, 99) < 2)) begin
               abort = 1'b1;
            end else if ($urandom_range(0, 99) < 5) begin
               op     = 2'($urandom_range(0, 3));
               rs_val = pick();
               rt_val = pick();
               start  = 1'b1;
            end
            cycle();
            abort = 1'b0;
            start = 1'b0;
         end
      end
      repeat (40) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
